sti_pack_ctrl: RTL and testbench
================================

# sti_pack_ctrl

Frame controller for the serial-to-DAC path. It receives a serial bit stream, sequences the 8-bit shift-in packer, and writes each completed byte to pixel memory at an auto-incrementing address. When the stream ends it writes any partial byte, zero-pads the remaining frame locations and signals completion. It sits between the serial input interface and the pixel memory write port.

## Interface
- FRAME_BYTES, 16, number of memory bytes per frame (≥1)
- ADDR_W, 4, pixel address width; 2^ADDR_W ≥ FRAME_BYTES
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- so_valid  in  1  serial bit valid; a contiguous high run is one frame
- so_data  in  1  serial bit, MSB-first within each byte
- pixel_wr  out  1  memory write strobe, one cycle per byte
- pixel_addr  out  ADDR_W  write address
- pixel_dout  out  8  write data
- busy  out  1  high in RECV, PAD and DONE
- done  out  1  one-cycle frame-complete pulse
- overflow  out  1  sticky: stream exceeded FRAME_BYTES·8 bits

## Operation
- Internal state: wptr (ADDR_W+1 bits, 0..FRAME_BYTES), bitcnt (3 bits), shift register sr[7:0].
- FSM states: IDLE, RECV, PAD, DONE.
- IDLE → RECV: so_valid=1 at an edge. That bit is captured as bit 0 of byte 0. overflow clears on this edge.
- RECV, so_valid=1, wptr<FRAME_BYTES:
  - shift {sr[6:0],so_data} and increment bitcnt.
  - On the 8th bit (bitcnt wraps 7→0), register pixel_wr=1, pixel_dout=completed byte, pixel_addr=wptr, then wptr+1.
- RECV, so_valid=1, wptr==FRAME_BYTES: bit discarded, overflow←1.
- RECV, so_valid=0 (end of stream):
  - Partial byte (bitcnt≠0) with wptr<FRAME_BYTES: write it left-aligned with zero LSBs (pixel_dout = sr shifted left by 8−bitcnt), then wptr+1.
  - Next state is PAD if wptr (after any write) < FRAME_BYTES, else DONE.
  - A partial byte with wptr==FRAME_BYTES is discarded and sets overflow.
- PAD: each edge writes 0x00 at wptr and increments wptr. After the write to address FRAME_BYTES−1, go to DONE. so_valid is ignored.
- DONE: done=1 for exactly this one cycle. Next edge → IDLE with wptr=0, bitcnt=0. so_valid is ignored. A new frame can start on the edge after DONE.
- Every byte address 0..FRAME_BYTES−1 is written exactly once per frame; there are no duplicate writes and no writes ≥FRAME_BYTES.

## Timing
- All outputs are registered.
- Reset values: pixel_wr=0, pixel_addr=0, pixel_dout=0, busy=0, done=0, overflow=0, state=IDLE, wptr=0, bitcnt=0, sr=0.
- Byte latency: pixel_wr is high in the cycle immediately after the edge that samples the 8th bit.
- The end-of-stream partial write appears in the cycle after the edge that samples so_valid=0.
- PAD issues one write per cycle with no gaps.
- done is high in the cycle after the last write, and also after the final full byte when no pad is needed and so_valid drops.
- Reset asserted mid-frame clears everything immediately; no further writes occur. The next frame restarts at address 0.

## Structure
- Shared package holds:
  - state enum (IDLE, RECV, PAD, DONE)
  - BYTE_W=8
  - PAD_BYTE=8'h00
- One sub-module, byte_deser: shift register plus bit counter with enable, emitting the byte, a byte_done flag, bitcnt and the left-aligned partial byte. The controller owns the FSM, wptr and output registers.

## Test plan
- 128 bits of pattern 0xA5 repeated, then so_valid=0 → 16 writes of 0xA5 at addr 0..15, each 1 cycle after its 8th bit; no pad; done pulses once; overflow=0.
- 20 ones then so_valid=0 → 0xFF@0, 0xFF@1, 0xF0@2, then 0x00@3..15 on 13 consecutive cycles, then a single done pulse.
- Single bit 1 → 0x80@0, pads 0x00@1..15, done.
- 136 bits → exactly 16 writes, overflow=1 with no 17th write; overflow clears when the next frame's first bit is sampled.
- so_valid re-asserted during PAD → ignored, pad sequence unchanged. A frame starting right after DONE writes to addr 0.
- rst pulsed mid-PAD (after addr 7) → all outputs zero at once, no further writes. The next 8-bit frame writes addr 0 and pads 1..15.

Source files
------------

// File: rtl/sti_pack_ctrl_pkg.sv
// Shared definitions for the serial-to-pixel frame packer.
//   state_t  : controller FSM states
//   BYTE_W   : width of one pixel memory word
//   PAD_BYTE : value written into frame locations the stream did not fill
package sti_pack_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sti_pack_ctrl_if.sv
// Serial input and pixel memory write bus of the frame packer.
//   so_valid/so_data             : serial bit stream (MSB first per byte)
//   pixel_wr/pixel_addr/pixel_dout : memory write port
// The master side is the controller: it consumes the serial stream and
// drives the memory write port. The slave side is the surrounding logic.
interface sti_pack_ctrl_if
  import sti_pack_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic              so_valid;
  logic              so_data;
  logic              pixel_wr;
  logic [ADDR_W-1:0] pixel_addr;
  logic [BYTE_W-1:0] pixel_dout;

  modport master (
    input  so_valid,
    input  so_data,
    output pixel_wr,
    output pixel_addr,
    output pixel_dout
  );

  modport slave (
    output so_valid,
    output so_data,
    input  pixel_wr,
    input  pixel_addr,
    input  pixel_dout
  );

endinterface

// File: rtl/sti_pack_ctrl_byte_deser.sv
// 8-bit shift-in packer with bit counter.
//   clk, rst    : clock, async active-high reset
//   en          : shift bit_in in (MSB first) and advance the bit counter
//   clr         : drop any partial byte (wins over en)
//   byte_out    : byte that completes if en is taken this cycle
//   byte_done   : en is high on the 8th bit of a byte
//   bitcnt      : bits held in the shift register
//   partial     : held bits left-aligned with zero LSBs
module byte_deser
  import sti_pack_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_done,
  output logic [2:0]        bitcnt,
  output logic [BYTE_W-1:0] partial
);

  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [2:0]        bitcnt_q, bitcnt_d;

  always_comb begin
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    if (clr) begin
      sr_d     = '0;
      bitcnt_d = '0;
    end else if (en) begin
      sr_d     = {sr_q[BYTE_W-2:0], bit_in};
      bitcnt_d = bitcnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q     <= '0;
      bitcnt_q <= '0;
    end else begin
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign byte_out  = {sr_q[BYTE_W-2:0], bit_in};
  assign byte_done = en && (bitcnt_q == 3'd7);
  assign bitcnt    = bitcnt_q;
  // Only meaningful for bitcnt 1..7; a shift of 8 yields zero.
  assign partial   = sr_q << (4'd8 - {1'b0, bitcnt_q});

endmodule

// File: rtl/sti_pack_ctrl.sv
// Frame controller: packs a serial stream into bytes, writes them to pixel
// memory at consecutive addresses, flushes a trailing partial byte,
// zero-pads the rest of the frame and pulses done.
//   clk, rst  : clock, async active-high reset
//   bus       : serial input and pixel write port (master modport)
//   busy      : frame in progress (RECV, PAD, DONE)
//   done      : one-cycle frame-complete pulse
//   overflow  : sticky, stream was longer than the frame; cleared by the
//               first bit of the next frame
//
// state | meaning
// IDLE  | waiting for the first valid bit of a frame
// RECV  | packing bits, writing each completed byte
// PAD   | writing PAD_BYTE until every frame address has been written
// DONE  | done pulse; wptr and packer return to zero
module sti_pack_ctrl
  import sti_pack_ctrl_pkg::*;
#(
  parameter int FRAME_BYTES = 16,
  parameter int ADDR_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  sti_pack_ctrl_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           overflow
);

  localparam logic [ADDR_W:0] FB       = (ADDR_W + 1)'(FRAME_BYTES);
  localparam logic [ADDR_W:0] WPTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic              pixel_wr_q, pixel_wr_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic [BYTE_W-1:0] pixel_dout_q, pixel_dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic              des_en, des_clr, des_done;
  logic [BYTE_W-1:0] des_byte, des_partial;
  logic [2:0]        des_bitcnt;

  byte_deser u_deser (
    .clk       (clk),
    .rst       (rst),
    .en        (des_en),
    .clr       (des_clr),
    .bit_in    (bus.so_data),
    .byte_out  (des_byte),
    .byte_done (des_done),
    .bitcnt    (des_bitcnt),
    .partial   (des_partial)
  );

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    pixel_wr_d   = 1'b0;
    pixel_addr_d = pixel_addr_q;
    pixel_dout_d = pixel_dout_q;
    overflow_d   = overflow_q;
    des_en       = 1'b0;
    des_clr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.so_valid) begin
          state_d    = RECV;
          des_en     = 1'b1;
          overflow_d = 1'b0;
        end
      end

      RECV: begin
        if (bus.so_valid) begin
          if (wptr_q < FB) begin
            des_en = 1'b1;
            if (des_done) begin
              pixel_wr_d   = 1'b1;
              pixel_addr_d = wptr_q[ADDR_W-1:0];
              pixel_dout_d = des_byte;
              wptr_d       = wptr_q + WPTR_ONE;
            end
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          des_clr = 1'b1;
          if (des_bitcnt != 3'd0) begin
            if (wptr_q < FB) begin
              pixel_wr_d   = 1'b1;
              pixel_addr_d = wptr_q[ADDR_W-1:0];
              pixel_dout_d = des_partial;
              wptr_d       = wptr_q + WPTR_ONE;
            end else begin
              overflow_d = 1'b1;
            end
          end
          state_d = (wptr_d < FB) ? PAD : DONE;
        end
      end

      // DONE follows once the last pad write has gone out, so done never
      // overlaps a pad write.
      PAD: begin
        if (wptr_q < FB) begin
          pixel_wr_d   = 1'b1;
          pixel_addr_d = wptr_q[ADDR_W-1:0];
          pixel_dout_d = PAD_BYTE;
          wptr_d       = wptr_q + WPTR_ONE;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        wptr_d  = '0;
        des_clr = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      pixel_wr_q   <= 1'b0;
      pixel_addr_q <= '0;
      pixel_dout_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      pixel_wr_q   <= pixel_wr_d;
      pixel_addr_q <= pixel_addr_d;
      pixel_dout_q <= pixel_dout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.pixel_wr   = pixel_wr_q;
  assign bus.pixel_addr = pixel_addr_q;
  assign bus.pixel_dout = pixel_dout_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_sti_pack_ctrl.sv
// Scoreboard bench for sti_pack_ctrl. Each frame task pushes the expected
// writes (cycle, address, data) and done pulse cycle; a negedge monitor pops
// and compares whenever the DUT strobes pixel_wr or done.
module tb_sti_pack_ctrl;

  localparam int FB = 16;
  localparam int AW = 4;

  typedef struct {
    int         t;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk;
  logic rst;
  logic busy, done, overflow;
  int   pcyc;
  int   checks;
  int   errors;
  bit   prev_ovf;

  wr_t exp_wr[$];
  int  exp_done[$];

  sti_pack_ctrl_if #(.ADDR_W(AW)) bus ();

  sti_pack_ctrl #(.FRAME_BYTES(FB), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, pcyc);
    end
  endtask

  function automatic void push_wr(input int t, input int a, input logic [7:0] d);
    wr_t w;
    w.t = t;
    w.a = 4'(a);
    w.d = d;
    exp_wr.push_back(w);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    wr_t e;
    while (exp_wr.size() > 0 && exp_wr[0].t < pcyc) begin
      e = exp_wr.pop_front();
      checks++;
      errors++;
      $display("FAIL write_missing: addr %0d data %h due cycle %0d, none by cycle %0d",
               e.a, e.d, e.t, pcyc);
    end
    while (exp_done.size() > 0 && exp_done[0] < pcyc) begin
      checks++;
      errors++;
      $display("FAIL done_missing: due cycle %0d, none by cycle %0d", exp_done.pop_front(), pcyc);
    end
    if (bus.pixel_wr) begin
      checks++;
      if (exp_wr.size() == 0 || exp_wr[0].t != pcyc) begin
        errors++;
        $display("FAIL write_unexpected: addr %0d data %h at cycle %0d, next expected cycle %0d",
                 bus.pixel_addr, bus.pixel_dout, pcyc,
                 (exp_wr.size() > 0) ? exp_wr[0].t : -1);
      end else begin
        e = exp_wr.pop_front();
        if (bus.pixel_addr !== e.a || bus.pixel_dout !== e.d) begin
          errors++;
          $display("FAIL write_data: got %h@%0d expected %h@%0d (cycle %0d)",
                   bus.pixel_dout, bus.pixel_addr, e.d, e.a, pcyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_done.size() == 0 || exp_done[0] != pcyc) begin
        errors++;
        $display("FAIL done_unexpected: at cycle %0d, next expected cycle %0d",
                 pcyc, (exp_done.size() > 0) ? exp_done[0] : -1);
      end else begin
        void'(exp_done.pop_front());
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.so_valid = 1'b0;
      bus.so_data  = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pixel_wr"},   {31'd0, bus.pixel_wr},   32'd0);
    chk({tag, "_pixel_addr"}, {28'd0, bus.pixel_addr}, 32'd0);
    chk({tag, "_pixel_dout"}, {24'd0, bus.pixel_dout}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy},           32'd0);
    chk({tag, "_done"},       {31'd0, done},           32'd0);
    chk({tag, "_overflow"},   {31'd0, overflow},       32'd0);
  endtask

  // Sends n bits of byte pattern pat (MSB first, repeating), then drops
  // so_valid. noise drives random valid bits during PAD/DONE. rst_after>=0
  // pulses reset just after the pad write to that address is visible.
  task automatic send_frame(input int n, input logic [7:0] pat, input bit noise,
                            input int rst_after);
    int         t0, nb, rem, w, tend, trst;
    bit         part;
    logic [7:0] mask;

    @(negedge clk);
    t0   = pcyc;
    nb   = (n / 8 > FB) ? FB : n / 8;
    rem  = n % 8;
    part = (rem != 0) && (n < FB * 8);
    mask = 8'hFF << (8 - rem);
    for (int k = 0; k < nb; k++) push_wr(t0 + 8 * k + 8, k, pat);
    if (part) push_wr(t0 + n + 1, nb, pat & mask);
    w = nb + (part ? 1 : 0);
    if (w < FB) begin
      for (int a = w; a < FB; a++)
        if (rst_after < 0 || a <= rst_after) push_wr(t0 + n + 2 + a - w, a, 8'h00);
      tend = t0 + n + 2 + FB - w;
    end else begin
      tend = t0 + n + 1;
    end
    if (rst_after < 0) exp_done.push_back(tend);

    for (int i = 0; i <= n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) chk("overflow_before_frame", {31'd0, overflow}, {31'd0, prev_ovf});
      if (i == 1) chk("overflow_cleared_by_first_bit", {31'd0, overflow}, 32'd0);
      bus.so_valid = (i < n);
      bus.so_data  = (i < n) ? pat[7 - (i % 8)] : 1'b0;
    end

    if (rst_after >= 0) begin
      trst = t0 + n + 2 + rst_after - w;
      while (pcyc < trst) begin
        @(negedge clk);
        bus.so_valid = 1'b0;
      end
      #1 rst = 1'b1;
      #1 chk_all_zero("mid_pad_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      prev_ovf = 1'b0;
      return;
    end

    while (pcyc < tend) begin
      @(negedge clk);
      bus.so_valid = noise;
      bus.so_data  = noise ? 1'($urandom) : 1'b0;
    end
    chk("overflow_at_done", {31'd0, overflow}, {31'd0, (n > FB * 8)});
    prev_ovf = (n > FB * 8);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    prev_ovf     = 1'b0;
    rst          = 1'b1;
    bus.so_valid = 1'b0;
    bus.so_data  = 1'b0;
    #2 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    send_frame(128, 8'hA5, 1'b0, -1);  // full frame, no pad
    idle(3);
    send_frame(20, 8'hFF, 1'b0, -1);   // FF FF F0 then 13 pads
    idle(2);
    send_frame(1, 8'hFF, 1'b0, -1);    // 80 then 15 pads
    idle(2);
    send_frame(136, 8'h3C, 1'b0, -1);  // overflow, 16 writes only
    idle(2);
    send_frame(12, 8'hC3, 1'b1, -1);   // C3 C0, pads with so_valid noise
    send_frame(16, 8'h69, 1'b0, -1);   // starts right after DONE
    idle(3);
    send_frame(1, 8'hFF, 1'b0, 7);     // reset after pad to addr 7
    idle(2);
    send_frame(8, 8'h5A, 1'b0, -1);    // 5A@0, pads 1..15
    idle(4);

    chk("leftover_writes", exp_wr.size(), 32'd0);
    chk("leftover_done", exp_done.size(), 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
